// File: rtl/axi_b_rr_arbiter.sv
// AXI B-channel arbiter/mux: collects write responses from N_SLV slaves and
// forwards one at a time to a single master, round-robin or fixed priority.
module axi_b_rr_arbiter #(
  parameter int N_SLV     = 4,
  parameter int IDW       = 8,
  parameter int PRIO_MODE = 0
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [N_SLV-1:0]     BVALID_S,
  input  logic [N_SLV*IDW-1:0] BID_S,
  input  logic [2*N_SLV-1:0]   BRESP_S,
  output logic [N_SLV-1:0]     BREADY_S,
  output logic                 BVALID_M,
  output logic [IDW-1:0]       BID_M,
  output logic [1:0]           BRESP_M,
  input  logic                 BREADY_M,
  output logic [N_SLV-1:0]     grant,
  output logic                 busy
);

  localparam int PW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [N_SLV-1:0] grant_q, grant_d;
  logic [N_SLV-1:0] hi_mask, hi_req, win_oh;
  logic             hs;
  int               g_idx;

  // Requests at or above ptr take precedence; otherwise wrap to the lowest index.
  // Fixed-priority mode leaves the mask empty so the lowest index always wins.
  always_comb begin
    hi_mask = '0;
    win_oh  = '0;
    for (int i = 0; i < N_SLV; i++) begin
      hi_mask[i] = (PRIO_MODE == 0) && (i >= int'(ptr_q));
    end
    hi_req = BVALID_S & hi_mask;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (hi_req == '0 && BVALID_S[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (hi_req[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    BVALID_M = 1'b0;
    BID_M    = '0;
    BRESP_M  = '0;
    BREADY_S = '0;
    g_idx    = 0;
    for (int i = 0; i < N_SLV; i++) begin
      if (state_q == BUSY && grant_q[i]) begin
        g_idx       = i;
        BVALID_M    = BVALID_S[i];
        BID_M       = BID_S[i*IDW +: IDW];
        BRESP_M     = BRESP_S[2*i +: 2];
        BREADY_S[i] = BREADY_M;
      end
    end
  end

  assign hs    = (state_q == BUSY) && BVALID_M && BREADY_M;
  assign grant = grant_q;
  assign busy  = (state_q == BUSY);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|BVALID_S) begin
          grant_d = win_oh;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (hs) begin
          state_d = IDLE;
          grant_d = '0;
          if (PRIO_MODE == 0) begin
            ptr_d = PW'((g_idx == N_SLV - 1) ? 0 : g_idx + 1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_axi_b_rr_arbiter.sv
// Bench for axi_b_rr_arbiter: a round-robin and a fixed-priority instance share
// stimulus and are compared each cycle against a transaction-level model.
module tb_axi_b_rr_arbiter;

  localparam int N   = 4;
  localparam int IDW = 8;

  logic               ACLK = 1'b0;
  logic               ARESETn = 1'b0;
  logic [N-1:0]       BVALID_S = '0;
  logic [N*IDW-1:0]   BID_S = '0;
  logic [2*N-1:0]     BRESP_S = '0;
  logic               BREADY_M = 1'b0;

  logic [N-1:0]   rr_bready_s, fp_bready_s, rr_grant, fp_grant;
  logic           rr_bvalid_m, fp_bvalid_m, rr_busy, fp_busy;
  logic [IDW-1:0] rr_bid_m, fp_bid_m;
  logic [1:0]     rr_bresp_m, fp_bresp_m;

  axi_b_rr_arbiter #(.N_SLV(N), .IDW(IDW), .PRIO_MODE(0)) u_rr (
    .ACLK(ACLK), .ARESETn(ARESETn), .BVALID_S(BVALID_S), .BID_S(BID_S),
    .BRESP_S(BRESP_S), .BREADY_S(rr_bready_s), .BVALID_M(rr_bvalid_m),
    .BID_M(rr_bid_m), .BRESP_M(rr_bresp_m), .BREADY_M(BREADY_M),
    .grant(rr_grant), .busy(rr_busy)
  );

  axi_b_rr_arbiter #(.N_SLV(N), .IDW(IDW), .PRIO_MODE(1)) u_fp (
    .ACLK(ACLK), .ARESETn(ARESETn), .BVALID_S(BVALID_S), .BID_S(BID_S),
    .BRESP_S(BRESP_S), .BREADY_S(fp_bready_s), .BVALID_M(fp_bvalid_m),
    .BID_M(fp_bid_m), .BRESP_M(fp_bresp_m), .BREADY_M(BREADY_M),
    .grant(fp_grant), .busy(fp_busy)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state per instance: 0 = round-robin, 1 = fixed priority.
  int m_busy [2];
  int m_g    [2];
  int m_ptr  [2];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int pick(input int mode, input int ptr, input logic [N-1:0] v);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = ((mode == 1) ? k : ptr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0;
      m_g[d]    = 0;
      m_ptr[d]  = 0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (m_busy[d] != 0) begin
        if (BVALID_S[m_g[d]] && BREADY_M) begin
          m_busy[d] = 0;
          if (d == 0) m_ptr[d] = (m_g[d] + 1) % N;
        end
      end else if (|BVALID_S) begin
        m_g[d]    = pick(d, m_ptr[d], BVALID_S);
        m_busy[d] = 1;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] e_grant, e_vld, e_id, e_resp, e_rdy;
    for (int d = 0; d < 2; d++) begin
      e_grant = '0; e_vld = '0; e_id = '0; e_resp = '0; e_rdy = '0;
      if (m_busy[d] != 0) begin
        e_grant = 32'(1) << m_g[d];
        e_vld   = 32'(BVALID_S[m_g[d]]);
        e_id    = 32'(BID_S[m_g[d]*IDW +: IDW]);
        e_resp  = 32'(BRESP_S[m_g[d]*2 +: 2]);
        e_rdy   = BREADY_M ? (32'(1) << m_g[d]) : 32'(0);
      end
      if (d == 0) begin
        chk("rr grant",    32'(rr_grant),    e_grant);
        chk("rr busy",     32'(rr_busy),     32'(m_busy[d]));
        chk("rr BVALID_M", 32'(rr_bvalid_m), e_vld);
        chk("rr BID_M",    32'(rr_bid_m),    e_id);
        chk("rr BRESP_M",  32'(rr_bresp_m),  e_resp);
        chk("rr BREADY_S", 32'(rr_bready_s), e_rdy);
      end else begin
        chk("fp grant",    32'(fp_grant),    e_grant);
        chk("fp busy",     32'(fp_busy),     32'(m_busy[d]));
        chk("fp BVALID_M", 32'(fp_bvalid_m), e_vld);
        chk("fp BID_M",    32'(fp_bid_m),    e_id);
        chk("fp BRESP_M",  32'(fp_bresp_m),  e_resp);
        chk("fp BREADY_S", 32'(fp_bready_s), e_rdy);
      end
    end
  endtask

  // Called just after a falling edge: drive, check mid-cycle, step at the rising edge.
  task automatic drive(input logic [N-1:0] v, input logic rdy);
    BVALID_S = v;
    BID_S    = {$urandom, $urandom};
    BRESP_S  = 8'($urandom);
    BREADY_M = rdy;
    #1 check_all();
    @(posedge ACLK);
    if (ARESETn) model_step();
    @(negedge ACLK);
  endtask

  task automatic reset_mid_cycle();
    BVALID_S = 4'($urandom);
    BID_S    = {$urandom, $urandom};
    BREADY_M = 1'b0;
    #2 ARESETn = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge ACLK);
    @(negedge ACLK);
    check_all();
    ARESETn = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge ACLK);
    @(negedge ACLK);
    check_all();
    ARESETn = 1'b1;

    // Single response from slave 1, then idle.
    drive(4'b0010, 1'b1);
    drive(4'b0010, 1'b1);
    repeat (3) drive(4'b0000, 1'b1);

    // All slaves requesting continuously.
    repeat (12) drive(4'b1111, 1'b1);

    // Backpressure while another slave starts requesting.
    drive(4'b0100, 1'b0);
    repeat (5) drive(4'b0101, 1'b0);
    repeat (4) drive(4'b0101, 1'b1);

    // Reset while busy, then all requesting again.
    drive(4'b1000, 1'b0);
    drive(4'b1000, 1'b0);
    reset_mid_cycle();
    repeat (6) drive(4'b1111, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) reset_mid_cycle();
      else drive(4'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
